uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit serializer: accepts one parallel word per handshake and drives a standard asynchronous frame on a single line, LSB first. A frame is one start bit (0), DATA_WIDTH data bits, an optional parity bit, and one stop bit (1). The block runs on the TX clock domain, one serial bit per clock cycle (clk = baud-rate clock). It is the transmit-side counterpart of the RX deserializer and uses the same bit ordering: the first bit on the line is data bit 0.

## Interface

Parameters:
- DATA_WIDTH, default 8, number of data bits per frame (legal range 5..9).

Ports:
- clk  input  1  TX clock; one serial bit per rising edge.
- rst  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  parallel word to send; sampled only on acceptance.
- data_valid  input  1  word-valid strobe from upstream.
- par_en  input  1  1 = insert parity bit; sampled on acceptance.
- par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
- tx_out  output  1  serial line; idles high.
- busy  output  1  high while start, data or parity bits are on the line; upstream may present a word only while low.

## Operation

- Reset (rst low, asynchronous): state IDLE, tx_out = 1, busy = 0, bit counter = 0, shift and parity registers = 0. Effect on outputs is immediate, mid-frame included. The partial frame is abandoned and not resumed.
- Acceptance: on a rising edge with busy = 0 and data_valid = 1, the block:
  - latches p_data, par_en and par_typ;
  - computes parity as XOR of p_data, inverted when par_typ = 1;
  - moves to START.
- While busy = 1, data_valid is ignored. p_data and the configuration inputs need not be held after acceptance.
- States:
  - IDLE: tx_out = 1, busy = 0. Goes to START on acceptance, otherwise stays.
  - START: tx_out = 0, busy = 1. Goes to DATA.
  - DATA: tx_out = shift register bit 0, busy = 1. The register shifts right each cycle and the counter increments. After DATA_WIDTH cycles, goes to PARITY if latched par_en = 1, else STOP.
  - PARITY: tx_out = latched parity bit, busy = 1. Goes to STOP.
  - STOP: tx_out = 1, busy = 0. Goes to START on acceptance (back-to-back, no idle gap), otherwise to IDLE.
- tx_out and busy are registered: no combinational path from any input to any output.
- Frame length: DATA_WIDTH + 2 cycles, plus 1 when parity is enabled.

## Timing

- Acceptance edge k: tx_out = 0 (start bit) and busy = 1 from edge k.
- Data bit i is driven from edge k+1+i.
- Parity (if enabled) is driven from edge k+1+DATA_WIDTH.
- Stop bit is driven from the following edge, with busy = 0 in the same cycle.
- Minimum word-to-word period is equal to the frame length. data_valid held high continuously produces contiguous frames.
- Latency from data_valid to the start bit on the line: 1 cycle.

## Test plan

- Reset: rst low mid-simulation with data_valid = 1 -> tx_out = 1 and busy = 0 immediately, and both stay so while rst is low.
- 0xA5, par_en = 0, single-cycle data_valid -> tx_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. busy is high for exactly 9 cycles, then the line idles at 1.
- 0xA5, par_en = 1:
  - par_typ = 0 (even) -> parity bit 0, 11-cycle frame.
  - par_typ = 1 (odd) -> parity bit 1, 11-cycle frame.
- Back-to-back: data_valid held high, p_data = 0x00 then 0xFF, no parity -> 0,0×8,1,0,1×8,1 with no extra idle cycle. The second start bit immediately follows the first stop bit.
- Ignore-while-busy: pulse data_valid with p_data = 0x3C at data bit 3 of a 0x81 frame -> the 0x81 frame completes unchanged and no 0x3C frame is sent.
- Reset mid-frame: assert rst during data bit 4, release, then send 0x55 -> line returns to 1 at once and the next frame is a clean 0x55 frame (0,1,0,1,0,1,0,1,0,1).

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit serializer: one word per handshake, framed as start, data (LSB first),
// optional parity and stop bit, one line bit per clock.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Even parity is the XOR of the word; odd parity inverts it.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Next-state and next-output logic; outputs are computed one edge ahead so they can be registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE, S_STOP: begin
        if (data_valid) begin
          state_d  = S_START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          shift_d  = p_data;
          par_d    = calc_parity(p_data, par_typ);
          par_en_d = par_en;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      S_DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_q;
            busy_d  = 1'b1;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames from the test plan plus random traffic
// checked cycle by cycle against a queue-based frame model.
module tb_uart_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          tx_out;
  logic          busy;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: expected (line, busy) per cycle; empty queue means an idle line.
  bit   q_tx[$];
  bit   q_busy[$];
  logic m_tx   = 1'b1;
  logic m_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    int ones = 0;
    q_tx.push_back(1'b0); q_busy.push_back(1'b1);
    for (int i = 0; i < DW; i++) begin
      q_tx.push_back(d[i]); q_busy.push_back(1'b1);
      ones += int'(d[i]);
    end
    if (pe) begin
      q_tx.push_back(((ones % 2) == 1) ^ pt); q_busy.push_back(1'b1);
    end
    q_tx.push_back(1'b1); q_busy.push_back(1'b0);
  endtask

  task automatic model_reset();
    q_tx.delete();
    q_busy.delete();
    m_tx   = 1'b1;
    m_busy = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic pe, input logic pt);
    data_valid = dv; p_data = d; par_en = pe; par_typ = pt;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (dv && !m_busy) push_frame(d, pe, pt);
      if (q_tx.size() > 0) begin
        m_tx   = q_tx.pop_front();
        m_busy = q_busy.pop_front();
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
    #1;
    check_eq("tx", {31'd0, tx_out}, {31'd0, m_tx});
    check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  // Send one word and record n line bits starting from the start bit.
  task automatic send_capture(input logic [DW-1:0] d, input logic pe, input logic pt, input int n,
                              output logic [31:0] bits, output int busy_cnt);
    bits = '0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle(i == 0, d, pe, pt);
      bits[i] = tx_out;
      busy_cnt += int'(busy);
    end
  endtask

  logic [31:0] bits;
  int          bcnt;
  int          seq_a5[10]   = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int          seq_55[10]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int          seq_b2b[20]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    // Reset held: outputs idle even with data_valid high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // 0xA5, no parity.
    send_capture(8'hA5, 1'b0, 1'b0, 12, bits, bcnt);
    for (int i = 0; i < 10; i++) check_eq($sformatf("a5_bit%0d", i), {31'd0, bits[i]}, seq_a5[i]);
    check_eq("a5_idle", {30'd0, bits[11:10]}, 32'd3);
    check_eq("a5_busy_cycles", bcnt, 32'd9);

    // 0xA5 with even then odd parity.
    send_capture(8'hA5, 1'b1, 1'b0, 12, bits, bcnt);
    check_eq("even_par", {31'd0, bits[9]}, 32'd0);
    check_eq("even_stop", {31'd0, bits[10]}, 32'd1);
    check_eq("even_busy_cycles", bcnt, 32'd10);
    send_capture(8'hA5, 1'b1, 1'b1, 12, bits, bcnt);
    check_eq("odd_par", {31'd0, bits[9]}, 32'd1);
    check_eq("odd_busy_cycles", bcnt, 32'd10);

    // Back-to-back with data_valid held high.
    bits = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(i <= 10, (i < 10) ? 8'h00 : 8'hFF, 1'b0, 1'b0);
      bits[i] = tx_out;
    end
    for (int i = 0; i < 20; i++) check_eq($sformatf("b2b_bit%0d", i), {31'd0, bits[i]}, seq_b2b[i]);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Ignore-while-busy: a 0x3C strobe at data bit 3 of a 0x81 frame.
    for (int i = 0; i < 14; i++) cycle(i == 0 || i == 4, (i == 4) ? 8'h3C : 8'h81, 1'b0, 1'b0);
    check_eq("ignore_idle_tx", {31'd0, tx_out}, 32'd1);
    check_eq("ignore_idle_busy", {31'd0, busy}, 32'd0);

    // Reset during data bit 4, then a clean 0x55 frame.
    for (int i = 0; i < 6; i++) cycle(i == 0, 8'h0F, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_tx", {31'd0, tx_out}, 32'd1);
    check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'hF0, 1'b1, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    send_capture(8'h55, 1'b0, 1'b0, 11, bits, bcnt);
    for (int i = 0; i < 10; i++) check_eq($sformatf("r55_bit%0d", i), {31'd0, bits[i]}, seq_55[i]);

    // Random traffic, including strobes while busy and long valid runs.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 2) == 0, DW'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
